// File: rtl/fsm_app_pkg.sv
// fsm_app_pkg: state encodings and helpers shared by the Fsm_APP blocks
package fsm_app_pkg;

    typedef enum logic [1:0] {
        S_LOW_STABLE  = 2'd0,
        S_WAIT_HIGH   = 2'd1,
        S_HIGH_STABLE = 2'd2,
        S_WAIT_LOW    = 2'd3
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/level_synchronizer.sv
// level_synchronizer: multi-flop synchroniser for an asynchronous level, resets to 0
module level_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r;

    // Shift the raw level through the flop chain
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r <= '0;
        else          r <= {r[STAGES-2:0], d};

    assign q = r[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a bouncing switch and qualifies each level change
module button_debouncer
    import fsm_app_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw,
    output logic db_level,
    output logic busy
);

    localparam int               CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sw_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    level_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sw),
        .q       (sw_s)
    );

    // Qualification FSM; a bounce on the terminal cycle aborts rather than completes
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= S_LOW_STABLE;
            cnt      <= '0;
            db_level <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_LOW_STABLE: begin
                    cnt <= '0;
                    if (sw_s) begin
                        state <= S_WAIT_HIGH;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT_HIGH:
                    if (!sw_s) begin
                        state <= S_LOW_STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == LAST) begin
                        state    <= S_HIGH_STABLE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        db_level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                S_HIGH_STABLE: begin
                    cnt <= '0;
                    if (!sw_s) begin
                        state <= S_WAIT_LOW;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT_LOW:
                    if (sw_s) begin
                        state <= S_HIGH_STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == LAST) begin
                        state    <= S_LOW_STABLE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        db_level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                default: begin
                    state    <= S_LOW_STABLE;
                    cnt      <= '0;
                    db_level <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: random and directed stimulus against a run-length reference model
module tb_button_debouncer;

    localparam int S = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sw = 1'b0;
    logic db_level, busy;

    int n_tests = 0;
    int n_fail  = 0;

    button_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw       (sw),
        .db_level (db_level),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference: the output flips once the synchronised input has disagreed with it
    // for D+1 consecutive samples; busy marks any non-empty disagreement run
    logic [S-1:0] m_pipe;
    logic         m_db;
    int           m_run;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            m_pipe <= '0;
            m_db   <= 1'b0;
            m_run  <= 0;
        end else begin
            m_pipe <= {m_pipe[S-2:0], sw};
            if (m_pipe[S-1] == m_db) m_run <= 0;
            else if (m_run == D) begin
                m_run <= 0;
                m_db  <= ~m_db;
            end else m_run <= m_run + 1;
        end

    // Cycle-by-cycle comparison against the model, away from the rising edge
    initial forever begin
        @(negedge clk);
        n_tests++;
        if (db_level !== m_db || busy !== (m_run != 0)) begin
            n_fail++;
            $display("FAIL model t=%0t db_level=%b busy=%b expected db_level=%b busy=%b",
                     $time, db_level, busy, m_db, (m_run != 0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic exp_db, input logic exp_busy);
        n_tests++;
        if (db_level !== exp_db || busy !== exp_busy) begin
            n_fail++;
            $display("FAIL %s db_level=%b busy=%b expected db_level=%b busy=%b",
                     name, db_level, busy, exp_db, exp_busy);
        end
    endtask

    initial begin
        // Reset held with the switch pressed
        sw = 1'b1;
        reset_n = 1'b0;
        step(3);
        check("reset_hold", 1'b0, 1'b0);
        reset_n = 1'b1;
        step(2);
        check("press_sync_latency", 1'b0, 1'b0);
        step(1);
        check("press_busy_start", 1'b0, 1'b1);
        step(3);
        check("press_busy_end", 1'b0, 1'b1);
        step(1);
        check("press_done", 1'b1, 1'b0);
        step(14);
        check("press_held", 1'b1, 1'b0);
        // Clean release: busy for exactly four cycles
        sw = 1'b0;
        step(2);
        check("release_sync_latency", 1'b1, 1'b0);
        step(1);
        check("release_busy_start", 1'b1, 1'b1);
        step(3);
        check("release_busy_end", 1'b1, 1'b1);
        step(1);
        check("release_done", 1'b0, 1'b0);
        step(5);
        // Bounce: high 3, low 2, high 2, low
        sw = 1'b1; step(3);
        sw = 1'b0; step(2);
        sw = 1'b1; step(2);
        sw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("bounce_no_change", 1'b0, db_level ? 1'b1 : busy);
            if (db_level !== 1'b0) break;
        end
        step(4);
        check("bounce_settled", 1'b0, 1'b0);
        // Drop on the terminal count aborts
        sw = 1'b1; step(4);
        sw = 1'b0; step(2);
        check("terminal_wait", 1'b0, 1'b1);
        step(1);
        check("terminal_abort", 1'b0, 1'b0);
        step(6);
        check("terminal_settled", 1'b0, 1'b0);
        // Reset during WAIT_LOW with cnt=2
        sw = 1'b1; step(10);
        check("mid_reset_high", 1'b1, 1'b0);
        sw = 1'b0; step(5);
        check("mid_reset_waiting", 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_async", 1'b0, 1'b0);
        sw = 1'b1;
        step(2);
        reset_n = 1'b1;
        step(6);
        check("resume_pending", 1'b0, 1'b1);
        step(1);
        check("resume_done", 1'b1, 1'b0);
        // Random bursts with occasional resets
        for (int k = 0; k < 600; k++) begin
            sw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                step(1);
                reset_n = 1'b1;
            end
            step($urandom_range(1, 9));
        end
        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
